// File: rtl/pushbutton_flagger.sv
// Two-channel pushbutton front end: sync, debounce, optional auto-repeat, and a
// sticky flag per channel that the consumer clears with a read pulse.
module pushbutton_flagger #(
  parameter int unsigned CLK_FREQ         = 50_000_000,
  parameter int unsigned DEBOUNCE_MS      = 10,
  parameter logic [1:0]  REPEAT_EN        = 2'b01,
  parameter int unsigned REPEAT_DELAY_MS  = 500,
  parameter int unsigned REPEAT_PERIOD_MS = 200,
  parameter bit          BTN_ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic PB0_raw,
  input  logic PB1_raw,
  input  logic PB0_read,
  input  logic PB1_read,
  output logic PB0_flag,
  output logic PB1_flag,
  output logic PB0_level,
  output logic PB1_level,
  output logic PB0_overrun,
  output logic PB1_overrun
);

  // state        | meaning
  // RELEASED     | debounced level 0, input idle
  // PRESS_WAIT   | input pressed, counting toward debounced press
  // PRESSED      | debounced level 1, repeat timer running if enabled
  // RELEASE_WAIT | input released, counting toward debounced release
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int unsigned DB_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned RD_CYC = CLK_FREQ / 1000 * REPEAT_DELAY_MS;
  localparam int unsigned RP_CYC = CLK_FREQ / 1000 * REPEAT_PERIOD_MS;

  localparam logic [31:0] DB_LIM = 32'(DB_CYC - 1);
  localparam logic [31:0] RD_LIM = 32'(RD_CYC - 1);
  localparam logic [31:0] RP_LIM = 32'(RP_CYC - 1);

  localparam logic IDLE_RAW = BTN_ACTIVE_LOW;

  logic [1:0] raw_v;
  logic [1:0] read_v;

  assign raw_v  = {PB1_raw, PB0_raw};
  assign read_v = {PB1_read, PB0_read};

  for (genvar i = 0; i < 2; i++) begin : g_ch
    localparam logic REP = REPEAT_EN[i];

    logic [1:0]  sync;
    logic        p;
    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic        level_q, level_nx;
    logic        rep_started, rep_nx;
    logic        flag_q, flag_nx;
    logic        ovr_q, ovr_nx;
    logic        event_c;

    // polarity is applied after the chain so reset can load the idle raw value
    assign p = sync[1] ^ IDLE_RAW;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync        <= {2{IDLE_RAW}};
        state       <= RELEASED;
        cnt         <= '0;
        level_q     <= 1'b0;
        rep_started <= 1'b0;
        flag_q      <= 1'b0;
        ovr_q       <= 1'b0;
      end else begin
        sync        <= {sync[0], raw_v[i]};
        state       <= state_nx;
        cnt         <= cnt_nx;
        level_q     <= level_nx;
        rep_started <= rep_nx;
        flag_q      <= flag_nx;
        ovr_q       <= ovr_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      level_nx = level_q;
      rep_nx   = rep_started;
      event_c  = 1'b0;
      case (state)
        RELEASED: begin
          if (p) begin
            state_nx = PRESS_WAIT;
            cnt_nx   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state_nx = RELEASED;
          end else if (cnt == DB_LIM) begin
            state_nx = PRESSED;
            event_c  = 1'b1;
            level_nx = 1'b1;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 32'd1;
          end
        end
        PRESSED: begin
          if (!p) begin
            state_nx = RELEASE_WAIT;
            cnt_nx   = '0;
          end else if (REP) begin
            if (cnt == (rep_started ? RP_LIM : RD_LIM)) begin
              event_c = 1'b1;
              cnt_nx  = '0;
              rep_nx  = 1'b1;
            end else begin
              cnt_nx = cnt + 32'd1;
            end
          end else begin
            cnt_nx = '0;
          end
        end
        RELEASE_WAIT: begin
          // a bounce back to pressed keeps the repeat phase, so no new first-delay
          if (p) begin
            state_nx = PRESSED;
            cnt_nx   = '0;
          end else if (cnt == DB_LIM) begin
            state_nx = RELEASED;
            level_nx = 1'b0;
            rep_nx   = 1'b0;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 32'd1;
          end
        end
        default: begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end
      endcase

      // a new event wins over a simultaneous read so no press is lost
      flag_nx = event_c | (flag_q & ~read_v[i]);
      ovr_nx  = event_c & flag_q & ~read_v[i];
    end
  end

  assign PB0_flag    = g_ch[0].flag_q;
  assign PB1_flag    = g_ch[1].flag_q;
  assign PB0_level   = g_ch[0].level_q;
  assign PB1_level   = g_ch[1].level_q;
  assign PB0_overrun = g_ch[0].ovr_q;
  assign PB1_overrun = g_ch[1].ovr_q;

endmodule
